// File: rtl/load_store_sequencer.sv
// load_store_sequencer
// Multi-cycle LOAD/STORE controller that sits between the MEM stage and a
// 64-bit data memory. It accepts one access at a time and runs it through
// IDLE -> CHECK -> REQ -> DONE over a req/ack handshake. It stalls the pipeline
// while an access is in flight. Misaligned/illegal accesses and memory
// timeouts are reported with resp_valid instead of hanging the core.

module load_store_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,

    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] load_data,
    output logic        misaligned,
    output logic        timeout,

    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The wait counter is compared against the last permitted no-ack cycle,
    // so mem_req stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;

    logic        is_store;
    logic [2:0]  f3_q;
    logic [63:0] addr_q;
    logic [63:0] sdata_q;
    logic [7:0]  wait_cnt;
    logic        mis_q;
    logic        to_q;
    logic [63:0] load_q;

    logic        is_mem_op;
    logic        accept;
    logic [2:0]  off;
    logic        bad_align;
    logic        illegal;
    logic        access_bad;
    logic [7:0]  base_mask;
    logic [63:0] lanes;
    logic [63:0] load_ext;
    logic        wait_expired;

    assign is_mem_op    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign accept       = (state == S_IDLE) && req_valid && is_mem_op;
    assign off          = addr_q[2:0];
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // Alignment and legality of the captured access, judged from its size.
    always_comb begin
        bad_align = 1'b0;
        case (f3_q[1:0])
            2'b01:   bad_align = addr_q[0];
            2'b10:   bad_align = |addr_q[1:0];
            2'b11:   bad_align = |addr_q[2:0];
            default: bad_align = 1'b0;
        endcase
        illegal    = is_store ? f3_q[2] : (f3_q == 3'b111);
        access_bad = bad_align | illegal;
    end

    // Byte-enable pattern for the access size before shifting into place.
    always_comb begin
        base_mask = 8'h00;
        case (f3_q[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Shift the returned doubleword down to the addressed byte and extend it.
    always_comb begin
        lanes    = mem_rdata >> {off, 3'b000};
        load_ext = 64'd0;
        case (f3_q)
            3'b000:  load_ext = {{56{lanes[7]}},  lanes[7:0]};
            3'b001:  load_ext = {{48{lanes[15]}}, lanes[15:0]};
            3'b010:  load_ext = {{32{lanes[31]}}, lanes[31:0]};
            3'b011:  load_ext = lanes;
            3'b100:  load_ext = {56'd0, lanes[7:0]};
            3'b101:  load_ext = {48'd0, lanes[15:0]};
            3'b110:  load_ext = {32'd0, lanes[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    // Next-state selection for the access sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_CHECK;
            S_CHECK: state_next = access_bad ? S_DONE : S_REQ;
            S_REQ:   if (mem_ack || wait_expired) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset drops any access in flight on the spot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request fields when an access is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= 64'd0;
            sdata_q  <= 64'd0;
        end else if (accept) begin
            is_store <= (opcode == OP_STORE);
            f3_q     <= funct3;
            addr_q   <= addr;
            sdata_q  <= store_data;
        end
    end

    // Wait counter and error flags: cleared on accept, set while the access runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else if (state == S_CHECK) begin
            if (access_bad) begin
                mis_q <= 1'b1;
            end
        end else if (state == S_REQ && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_expired) begin
                to_q <= 1'b1;
            end
        end
    end

    // Result register: updated only when an access finishes, held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_q <= 64'd0;
        end else if (state == S_CHECK && access_bad) begin
            load_q <= 64'd0;
        end else if (state == S_REQ) begin
            if (mem_ack) begin
                load_q <= is_store ? 64'd0 : load_ext;
            end else if (wait_expired) begin
                load_q <= 64'd0;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign stall      = (state == S_CHECK) || (state == S_REQ) || accept;
    assign resp_valid = (state == S_DONE);
    assign load_data  = load_q;
    assign misaligned = mis_q;
    assign timeout    = to_q;

    assign mem_req    = (state == S_REQ);
    assign mem_we     = (state == S_REQ) && is_store;
    assign mem_addr   = {addr_q[63:3], 3'b000};
    assign mem_wdata  = is_store ? (sdata_q << {off, 3'b000}) : 64'd0;
    assign mem_wmask  = is_store ? (base_mask << off) : 8'h00;

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Multi-cycle controller between the core's MEM stage and the 64-bit data memory. Sequences LOAD (opcode 0000011) and STORE (opcode 0100011) accesses over a req/ack memory handshake.
- Computes byte lanes and write mask. Sign- or zero-extends load data per RV64 funct3. Stalls the pipeline until the access completes.
- Flags misaligned accesses and memory timeouts instead of issuing or hanging.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles to wait for mem_ack before aborting (1..255).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a memory instruction
- req_ready  output  1  sequencer can accept a request (IDLE only)
- opcode  input  7  instruction opcode, sampled on accept
- funct3  input  3  access size/sign, sampled on accept
- addr  input  64  byte address, sampled on accept
- store_data  input  64  store source (rs2), value in low bits
- stall  output  1  high while an accepted access is in flight
- resp_valid  output  1  one-cycle pulse when the access finishes
- load_data  output  64  extended load result, valid with resp_valid
- misaligned  output  1  valid with resp_valid: address not aligned to size
- timeout  output  1  valid with resp_valid: memory did not ack in time
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1 = write
- mem_addr  output  64  doubleword-aligned address ({addr[63:3],3'b000})
- mem_wdata  output  64  store data shifted to byte lanes
- mem_wmask  output  8  byte-enable mask
- mem_ack  input  1  memory completes request (rdata valid same cycle)
- mem_rdata  input  64  doubleword read data

Behaviour:
- Reset (async, reset_n=0): state IDLE. req_ready=1. All other outputs 0, including load_data, mem_addr, mem_wdata and mem_wmask. Wait counter 0.
- Reset asserted mid-access: the access is dropped immediately and mem_req falls; no resp_valid is produced.
- Accept: in IDLE, req_valid=1 with opcode LOAD or STORE. Register opcode, funct3, addr and store_data.
- Non-memory opcode with req_valid is ignored: it stays IDLE and emits no resp_valid.
- Alignment checks on the sampled values:
  - size from funct3[1:0]: 00=1 B, 01=2 B, 10=4 B, 11=8 B.
  - misaligned if (size 2 and addr[0]), (size 4 and addr[1:0]≠0), or (size 8 and addr[2:0]≠0).
  - illegal loads: funct3=111 is treated as misaligned.
  - illegal stores: funct3[2]=1 is treated as misaligned.
- State machine IDLE→CHECK→REQ→DONE→IDLE:
  - CHECK (1 cycle): if misaligned, go to DONE with the error set and no memory request issued. Otherwise go to REQ.
  - REQ: mem_req=1, with mem_we/mem_addr/mem_wdata/mem_wmask stable.
    - On mem_ack: capture mem_rdata and go to DONE.
    - The wait counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, drop mem_req, set timeout and go to DONE.
  - DONE (1 cycle): resp_valid=1, stall=0, with load_data/misaligned/timeout valid. Then return to IDLE. Error flags and the counter clear on the next accept.
- stall=1 in CHECK and REQ. It is combinationally high in the accept cycle (IDLE with a valid memory req_valid).
- Minimum latency, accept to resp_valid: a hit with mem_ack in the first REQ cycle gives 3 cycles. A misaligned access gives 2.
- Store lanes, with off=addr[2:0]:
  - mem_wdata = store_data << (8*off).
  - mem_wmask = base << off, where base is 0x01/0x03/0x0F/0xFF for 1/2/4/8 B.
- Load data: lanes = captured mem_rdata >> (8*off), then extended by funct3:
  - 000 LB: sext from bit 7.
  - 001 LH: sext from bit 15.
  - 010 LW: sext from bit 31.
  - 011 LD: full 64 bits.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
- Stores return load_data=0. Errored accesses return load_data=0.
- load_data holds its value until the next resp_valid.
- mem_ack outside REQ is ignored.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x0000_0000_8000_0000 (byte3=0x80), ack in the first REQ cycle → resp_valid 3 cycles after accept, load_data=0xFFFF_FFFF_FFFF_FF80. Repeat as LBU → 0x0000_0000_0000_0080.
- LW, addr=0x2004, mem_rdata=0x8765_4321_0000_0000 → load_data=0xFFFF_FFFF_8765_4321. LWU → 0x0000_0000_8765_4321. mem_addr=0x2000 in both cases.
- SH, addr=0x3006, store_data=0x...BEEF → mem_we=1, mem_wmask=0xC0, mem_wdata=0xBEEF_0000_0000_0000. mem_req is held across 3 no-ack cycles, then resp_valid follows ack.
- LD, addr=0x4004 → misaligned=1 with resp_valid 2 cycles after accept, mem_req never asserted, load_data=0.
- SW, addr=0x5000, mem_ack never asserted, TIMEOUT_CYCLES=16 → mem_req high for exactly 16 cycles, then resp_valid with timeout=1. The next access clears timeout.
- reset_n pulsed low during REQ → mem_req=0 and stall=0 immediately, req_ready=1, no resp_valid. Back-to-back LD requests after reset each complete correctly.
